// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and helpers for the UART receive path.
//   uart_rx_state_t  : receiver FSM states (PARITY is only used when the
//                      UART_RX_PARITY_EN macro is defined)
//   UART_DATA_W      : payload width of one UART character
//   uart_even_parity : even-parity bit for a byte (XOR reduction)
// ---------------------------------------------------------------------------
package uart_pkg;

   localparam int UART_DATA_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK
   } uart_rx_state_t;

   // Bit that makes data plus parity contain an even number of ones.
   function automatic logic uart_even_parity(input logic [UART_DATA_W-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/uart_sync.sv
// ---------------------------------------------------------------------------
// uart_sync
// Two-flop synchroniser for a single asynchronous input.
// Ports:
//   clk  (in)  destination clock
//   rst  (in)  asynchronous active-high reset, loads RST_VAL into both flops
//   d_i  (in)  asynchronous input
//   q_o  (out) synchronised input, two clk cycles of latency
// RST_VAL defaults to 1 so an idle-high UART line looks idle out of reset.
// ---------------------------------------------------------------------------
module uart_sync #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// UART receiver, 8N1, LSB first, idle-high line. Deserialises sin into bytes
// and hands them downstream over a valid/ready handshake.
// Ports:
//   clk         (in)  system clock
//   rst         (in)  asynchronous active-high reset
//   sin         (in)  serial line, asynchronous to clk
//   rx_data     (out) received byte, stable while rx_valid is high
//   rx_valid    (out) byte available
//   rx_ready    (in)  consumer takes the byte when rx_valid && rx_ready
//   frame_err   (out) one-cycle pulse, stop bit sampled low
//   overrun_err (out) one-cycle pulse, byte completed while previous unread
//   busy        (out) high whenever the FSM is not in IDLE
//   parity_err  (out) only with UART_RX_PARITY_EN: one-cycle pulse alongside
//                     delivery of a byte whose even parity check failed
// Optional feature macro: UART_RX_PARITY_EN adds an even parity bit between
// the data bits and the stop bit (8E1). Without it the receiver is pure 8N1.
// ---------------------------------------------------------------------------
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   sin,
   output logic [UART_DATA_W-1:0] rx_data,
   output logic                   rx_valid,
   input  logic                   rx_ready,
   output logic                   frame_err,
   output logic                   overrun_err,
   output logic                   busy
`ifdef UART_RX_PARITY_EN
   ,output logic                  parity_err
`endif
);

   localparam int HALF_BIT = CLKS_PER_BIT / 2;
   localparam int CNT_W    = $clog2(CLKS_PER_BIT);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);

   if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535 || (CLKS_PER_BIT % 2) != 0) begin : g_bad_cfg
      $error("uart_rx: CLKS_PER_BIT must be even and within 4..65535");
   end

   logic                   sin_s;
   uart_rx_state_t         state_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [2:0]             idx_q;
   logic [UART_DATA_W-1:0] shreg_q;
   logic                   stop_ok_q;
   logic                   frame_err_q;
   logic                   busy_q;
   logic                   bit_tick;

   logic [UART_DATA_W-1:0] rx_data_q, rx_data_d;
   logic                   rx_valid_q, rx_valid_d;
   logic                   overrun_q, overrun_d;

`ifdef UART_RX_PARITY_EN
   logic                   par_bit_q;
   logic                   parity_err_q, parity_err_d;
`endif

   uart_sync #(.RST_VAL(1'b1)) u_sync (
      .clk (clk),
      .rst (rst),
      .d_i (sin),
      .q_o (sin_s)
   );

   // Every state that times a bit reaches its sample point when cnt hits 0.
   assign bit_tick = (cnt_q == '0);

   // Receiver FSM. busy is registered alongside the state so it equals
   // (state != IDLE) without a decode after the flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         stop_ok_q   <= 1'b0;
         frame_err_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         stop_ok_q   <= 1'b0;
         frame_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!sin_s) begin
                  state_q <= START;
                  cnt_q   <= CNT_HALF;
                  busy_q  <= 1'b1;
               end
            end
            START: begin
               if (bit_tick) begin
                  // A start bit that is no longer low at mid-bit was a glitch.
                  if (!sin_s) begin
                     state_q <= DATA;
                     cnt_q   <= CNT_FULL;
                     idx_q   <= '0;
                  end else begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            DATA: begin
               if (bit_tick) begin
                  cnt_q <= CNT_FULL;
                  if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state_q <= PARITY;
`else
                     state_q <= STOP;
`endif
                  end else begin
                     idx_q <= idx_q + 3'd1;
                  end
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (bit_tick) begin
                  state_q <= STOP;
                  cnt_q   <= CNT_FULL;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
`endif
            STOP: begin
               // Leaving at mid-stop-bit leaves half a bit to rearm for a
               // back-to-back start edge.
               if (bit_tick) begin
                  if (sin_s) begin
                     state_q   <= IDLE;
                     busy_q    <= 1'b0;
                     stop_ok_q <= 1'b1;
                  end else begin
                     state_q     <= BREAK;
                     frame_err_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            BREAK: begin
               // Wait for the line to return high so a held-low line does
               // not look like a stream of start bits.
               if (sin_s) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Payload capture; only read after a completed frame, so no reset needed.
   always_ff @(posedge clk) begin
      if (state_q == DATA && bit_tick) begin
         shreg_q[idx_q] <= sin_s;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk) begin
      if (state_q == PARITY && bit_tick) begin
         par_bit_q <= sin_s;
      end
   end
`endif

   // Output register: a good frame loads only if the slot is free or being
   // emptied this very cycle; otherwise the new byte is dropped as overrun.
   always_comb begin
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q;
      overrun_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_d = 1'b0;
`endif
      if (rx_valid_q && rx_ready) begin
         rx_valid_d = 1'b0;
      end
      if (stop_ok_q) begin
         if (!rx_valid_q || rx_ready) begin
            rx_data_d  = shreg_q;
            rx_valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_err_d = uart_even_parity(shreg_q) ^ par_bit_q;
`endif
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         overrun_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err_q <= 1'b0;
`endif
      end else begin
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         overrun_q  <= overrun_d;
`ifdef UART_RX_PARITY_EN
         parity_err_q <= parity_err_d;
`endif
      end
   end

   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign frame_err   = frame_err_q;
   assign overrun_err = overrun_q;
   assign busy        = busy_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err  = parity_err_q;
`endif

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver on the master side of the UART bus: deserialises the `sin` line into bytes.
- Stage directly downstream of the `uart_bus` interface; feeds bytes to the local bus or CPU peripheral logic over a valid/ready handshake.
- Frame format: 8N1, LSB first, idle-high line.
- Reports framing errors, overrun errors and line breaks.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200). Legal range 4..65535, even values only; checked by an elaboration-time assertion.
- HALF_BIT, CLKS_PER_BIT/2, mid-bit sample offset (derived, not overridable).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- sin  input  1  serial line from `uart_bus.master.sin`; asynchronous to `clk`
- rx_data  output  8  received byte, stable while rx_valid=1
- rx_valid  output  1  byte available
- rx_ready  input  1  consumer accepts byte when rx_valid&&rx_ready
- frame_err  output  1  one-cycle pulse: stop bit sampled 0
- overrun_err  output  1  one-cycle pulse: byte completed while previous byte unaccepted
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset values: rx_data=8'h00, rx_valid=0, frame_err=0, overrun_err=0, busy=0, FSM=IDLE, synchroniser flops=1 (idle line).
- Reset is asynchronous: asserting rst mid-frame aborts the frame immediately. No partial byte is ever delivered.
- Synchroniser: 2-FF on `sin` gives `sin_s`, 2 clk latency. All FSM decisions use `sin_s` only.
- Bit counter: down-counter `cnt` of width $clog2(CLKS_PER_BIT). Bit index `idx` is 3 bits.
- IDLE: when sin_s=0, go to START and load cnt=HALF_BIT-1.
- START: decrement cnt. At cnt==0:
  - if sin_s=0, go to DATA with cnt=CLKS_PER_BIT-1 and idx=0;
  - else treat as a glitch and go to IDLE with no error.
- DATA: decrement cnt. At cnt==0:
  - shift sin_s into shreg[idx] (LSB first) and reload cnt=CLKS_PER_BIT-1;
  - if idx==7 go to STOP, else idx++.
- STOP: at cnt==0, sample sin_s:
  - sin_s=1: the byte is good; go to IDLE. The FSM returns to IDLE at mid-stop-bit, so back-to-back frames are supported.
  - sin_s=0: pulse frame_err, discard the byte, go to BREAK.
- BREAK: hold until sin_s=1, then go to IDLE. This stops a held-low line from retriggering START.
- Byte delivery, one cycle after the good stop sample:
  - if rx_valid=0 or rx_ready=1 in that cycle: rx_data<=shreg, rx_valid<=1;
  - else: pulse overrun_err; old rx_data and rx_valid are kept; the new byte is dropped.
- rx_valid clears on the cycle after handshake unless a new byte loads in the same cycle. In that case rx_valid stays 1 with the new data.
- Latency, sin falling edge to rx_valid rising = 2 + 1 + HALF_BIT + 9*CLKS_PER_BIT + 1 cycles (156 for CLKS_PER_BIT=16).
- frame_err and overrun_err are never asserted together (they come from different stop-sample outcomes).

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - adds state PARITY between DATA and STOP;
  - samples the bit at mid-bit and checks even parity over data plus parity bit;
  - adds output parity_err (1 bit), a one-cycle pulse coincident with byte delivery;
  - the byte is still delivered on parity error.
  - Latency grows by CLKS_PER_BIT.
- Undefined: no PARITY state, no parity_err port, pure 8N1.

Decomposition:
- Package uart_pkg:
  - enum uart_rx_state_t {IDLE, START, DATA, PARITY, STOP, BREAK}; PARITY is present unconditionally, unused when the macro is off;
  - localparam UART_DATA_W=8;
  - function uart_even_parity(logic [7:0]).
- Sub-module uart_sync: 2-FF synchroniser with reset value parameter RST_VAL=1. Reusable by a future uart_tx CTS input.

Test Plan (CLKS_PER_BIT=16):
- Send 8'hA5 in 8N1, rx_ready=1 → rx_data=8'hA5, rx_valid high exactly 156 cycles after the start edge, for 1 cycle; no errors.
- Send 0x00, 0xFF and 0x55 back-to-back with no idle gap, rx_ready=1 → three deliveries in order, no frame_err.
- 5-cycle low glitch on sin from idle → FSM returns to IDLE, busy drops, no rx_valid, no frame_err.
- Frame 0x3C with stop bit forced 0, line held low 40 bit-times → one frame_err pulse, no rx_valid, no retrigger until sin high; next frame 0x81 received correctly.
- rx_ready=0, send 0x11 then 0x22 → rx_data stays 0x11, overrun_err pulses once at the 0x22 stop. Raise rx_ready → rx_valid drops.
- rst asserted mid-DATA of 0x7E, released; then send 0x42 → all outputs at reset values during reset; only 0x42 delivered.
- UART_RX_PARITY_EN defined, 0x07 with parity bit 0 → rx_data=0x07, parity_err=1 pulse.
